// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: frame-synchronous servo pulse-width target tracker with per-frame slew limit
module servo_slew_ctrl #(
  parameter int PERIOD_CYCLES = 2000000,
  parameter int MIN_PULSE = 100000,
  parameter int MAX_PULSE = 200000,
  parameter int PULSE_LSB = 392,
  parameter int STEP = 500,
  parameter int CNT_W = 21
) (
  input  logic             clk_pwm,
  input  logic             clr_pwm,
  input  logic [7:0]       tgt_pos,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  output logic [CNT_W-1:0] pulse_width,
  output logic             pw_update,
  output logic             frame_start,
  output logic             busy
);
  typedef enum logic {IDLE, SLEW} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] CENTER = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);
  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP);
  localparam logic [CNT_W:0] MIN_X = (CNT_W+1)'(MIN_PULSE);
  localparam logic [CNT_W:0] LSB_X = (CNT_W+1)'(PULSE_LSB);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cur, tgt, cur_nx, tgt_nx, diff, step;
  logic [CNT_W:0] raw;
  logic fs_q, upd_q, wrap, acc, up;
  assign wrap = cnt == LAST;
  assign acc = tgt_valid && tgt_ready;
  always_comb begin
    raw = MIN_X + (CNT_W+1)'(tgt_pos) * LSB_X;
    tgt_nx = acc ? (raw > {1'b0, MAXP} ? MAXP : raw[CNT_W-1:0]) : tgt;
    up = tgt > cur;
    diff = up ? tgt - cur : cur - tgt;
    step = diff < STEP_W ? diff : STEP_W;
    cur_nx = (wrap && state == SLEW) ? (up ? cur + step : cur - step) : cur;
  end
  always_ff @(posedge clk_pwm) begin
    if (!clr_pwm) begin
      cnt <= '0;
      cur <= CENTER;
      tgt <= CENTER;
      fs_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      cur <= cur_nx;
      tgt <= tgt_nx;
      fs_q <= wrap;
      upd_q <= wrap && state == SLEW;
    end
  end
  always_ff @(posedge clk_pwm) begin
    if (!clr_pwm) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = acc ? (tgt_nx == cur ? IDLE : SLEW) : ((wrap && cur_nx == tgt) ? IDLE : state);
  end
  always_comb begin
    tgt_ready = clr_pwm && !wrap;
    pulse_width = clr_pwm ? cur : CENTER;
    frame_start = clr_pwm && fs_q;
    pw_update = clr_pwm && upd_q;
    busy = clr_pwm && state == SLEW;
  end
endmodule

// File: tb/tb_servo_slew_ctrl.sv
// tb_servo_slew_ctrl: frame-level reference model with scoreboard for servo_slew_ctrl
module tb_servo_slew_ctrl;
  localparam int P = 100, MN = 10, MX = 60, LSB = 1, ST = 4, W = 8, CTR = 35;
  typedef struct {int pw; int upd; int bsy;} frame_t;
  logic clk_pwm = 1'b0;
  logic clr_pwm = 1'b0;
  logic tgt_valid = 1'b0;
  logic [7:0] tgt_pos = 8'd0;
  logic tgt_ready, pw_update, frame_start, busy;
  logic [W-1:0] pulse_width;
  int n_tests = 0, n_fail = 0;
  int m_cnt = 0, m_cur = CTR, m_tgt = CTR;
  bit m_fs = 1'b0, started = 1'b0;
  frame_t exp_q[$];
  servo_slew_ctrl #(
    .PERIOD_CYCLES(P), .MIN_PULSE(MN), .MAX_PULSE(MX),
    .PULSE_LSB(LSB), .STEP(ST), .CNT_W(W)
  ) dut (
    .clk_pwm(clk_pwm), .clr_pwm(clr_pwm), .tgt_pos(tgt_pos), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready), .pulse_width(pulse_width), .pw_update(pw_update),
    .frame_start(frame_start), .busy(busy)
  );
  always #5 clk_pwm = ~clk_pwm;
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_edge(input bit c, input bit v, input int p);
    int old;
    m_fs = 1'b0;
    if (!c) begin
      m_cnt = 0;
      m_cur = CTR;
      m_tgt = CTR;
      exp_q.delete();
      return;
    end
    if (m_cnt == P - 1) begin
      old = m_cur;
      if (m_cur < m_tgt) m_cur = (m_cur + ST > m_tgt) ? m_tgt : m_cur + ST;
      else if (m_cur > m_tgt) m_cur = (m_cur - ST < m_tgt) ? m_tgt : m_cur - ST;
      m_cnt = 0;
      m_fs = 1'b1;
      exp_q.push_back('{m_cur, int'(old != m_cur), int'(m_cur != m_tgt)});
    end else begin
      if (v) m_tgt = (MN + p * LSB > MX) ? MX : MN + p * LSB;
      m_cnt++;
    end
  endfunction
  task automatic cyc(input bit c, input bit v, input logic [7:0] p);
    clr_pwm = c;
    tgt_valid = v;
    tgt_pos = p;
    @(posedge clk_pwm);
    model_edge(c, v, int'(p));
    #1;
  endtask
  task automatic run_frames(input int n);
    repeat (n * P) cyc(1'b1, 1'b0, 8'd0);
  endtask
  task automatic run_to(input int k);
    for (int i = 0; i < 2 * P && m_cnt != k; i++) cyc(1'b1, 1'b0, 8'd0);
    check("run_to_counter", m_cnt, k);
  endtask
  always @(negedge clk_pwm) begin
    frame_t e;
    if (started) begin
      check("tgt_ready", int'(tgt_ready), int'(clr_pwm && m_cnt != P - 1));
      check("busy", int'(busy), int'(clr_pwm && m_cur != m_tgt));
      check("pulse_width", int'(pulse_width), clr_pwm ? m_cur : CTR);
      check("frame_start", int'(frame_start), int'(clr_pwm && m_fs));
      if (frame_start) begin
        if (exp_q.size() == 0) check("frame_queue_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("frame_pw", int'(pulse_width), e.pw);
          check("frame_pw_update", int'(pw_update), e.upd);
          check("frame_busy", int'(busy), e.bsy);
        end
      end else check("pw_update_idle", int'(pw_update), 0);
    end
  end
  initial begin
    started = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 8'd0);
    run_to(5);
    cyc(1'b1, 1'b1, 8'd10);
    run_frames(6);
    repeat (2) cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 8'd255);
    run_frames(8);
    run_to(99);
    cyc(1'b1, 1'b1, 8'd0);
    cyc(1'b1, 1'b1, 8'd0);
    run_frames(2);
    repeat (2) cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 8'd10);
    run_frames(2);
    run_to(20);
    cyc(1'b1, 1'b1, 8'd40);
    cyc(1'b1, 1'b1, 8'd25);
    run_frames(3);
    cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 8'd255);
    run_frames(2);
    run_to(50);
    cyc(1'b0, 1'b0, 8'd0);
    run_frames(2);
    repeat (6000) cyc($urandom_range(0, 999) != 0, $urandom_range(0, 19) == 0, 8'($urandom));
    @(negedge clk_pwm);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/servo_slew_ctrl.md
SERVO_SLEW_CTRL -- requirements
Module: servo_slew_ctrl

Interface
REQ-001 SHALL provide parameter PERIOD_CYCLES, default 2000000, meaning clk_pwm cycles per servo frame (20 ms at 100 MHz).
REQ-002 SHALL provide parameter MIN_PULSE, default 100000, meaning the minimum pulse width in cycles.
REQ-003 SHALL provide parameter MAX_PULSE, default 200000, meaning the maximum pulse width in cycles.
REQ-004 SHALL provide parameter PULSE_LSB, default 392, meaning the pulse cycles added per tgt_pos count.
REQ-005 SHALL provide parameter STEP, default 500, meaning the maximum pulse-width change per frame.
REQ-006 SHALL provide parameter CNT_W, default 21, meaning the width of the counter and pulse-width datapath.
REQ-007 SHALL provide port clk_pwm, input, width 1: the single clock; all logic is on its rising edge.
REQ-008 SHALL provide port clr_pwm, input, width 1: synchronous, active-low reset.
REQ-009 SHALL provide port tgt_pos, input, width 8: the target servo position.
REQ-010 SHALL provide port tgt_valid, input, width 1: tgt_pos is valid.
REQ-011 SHALL provide port tgt_ready, output, width 1: the block accepts tgt_pos this cycle.
REQ-012 SHALL provide port pulse_width, output, width CNT_W: the current commanded high time in cycles, for the downstream PWM generator.
REQ-013 SHALL provide port pw_update, output, width 1: a one-cycle strobe indicating that pulse_width changed at this frame start.
REQ-014 SHALL provide port frame_start, output, width 1: a one-cycle strobe on the first cycle of each frame.
REQ-015 SHALL provide port busy, output, width 1: the current pulse width differs from the target pulse width.

Function
REQ-016 Frame counter SHALL count 0..PERIOD_CYCLES-1 and then wrap to 0.
REQ-017 frame_start SHALL be registered: high only in the cycle where the counter equals 0 following a wrap, never in the first frame after reset.
REQ-018 tgt_ready SHALL be 1 in every non-reset cycle, except when the counter equals PERIOD_CYCLES-1.
REQ-019 On tgt_valid && tgt_ready, the target SHALL be set to MIN_PULSE + tgt_pos*PULSE_LSB, clamped to MAX_PULSE; the computation uses CNT_W+1 bits internally, so there is no overflow.
REQ-020 Consecutive accepts within a frame SHALL overwrite the target; the last accept wins.
REQ-021 The FSM SHALL have state IDLE (current == target) and state SLEW (current != target); accepting a differing target moves IDLE->SLEW; reaching the target at a wrap moves SLEW->IDLE.
REQ-022 On the wrap edge in SLEW, current SHALL move toward the target by min(STEP, |target-current|), never overshooting.
REQ-023 pulse_width SHALL equal current and change only on the wrap edge (latency of one frame boundary after accept).
REQ-024 pw_update SHALL be high in the frame_start cycle if and only if pulse_width changed on that wrap.
REQ-025 busy SHALL be 1 exactly when the state is SLEW; it is combinational from registers.
REQ-026 If a target equal to current is accepted while in SLEW, the block SHALL go to IDLE with no pulse_width change.

Reset
REQ-027 While clr_pwm == 0 at a clock edge, the block SHALL set: counter 0; current and target to (MIN_PULSE+MAX_PULSE)/2; state IDLE.
REQ-028 While clr_pwm == 0, the block SHALL drive: pulse_width = center; frame_start, pw_update, busy and tgt_ready all 0.
REQ-029 Reset asserted mid-slew SHALL abandon the slew, with pulse_width = center on the next cycle; tgt_ready = 1 from the first cycle after release.

Verification (PERIOD_CYCLES=100, MIN_PULSE=10, MAX_PULSE=60, PULSE_LSB=1, STEP=4, CNT_W=8; center 35)
REQ-030 Reset for 3 cycles, then release -> pulse_width=35, busy=0, pw_update=0, tgt_ready=0 during reset and 1 after; first frame_start 100 cycles after release.
REQ-031 Accept tgt_pos=10 at counter=5 -> busy=1; pulse_width 31, 27, 23, 20 at successive wraps, each with pw_update=1; busy=0 after the 20; the next wrap has pw_update=0.
REQ-032 Accept tgt_pos=255 -> target clamps to 60; pulse_width 39, 43, ..., 59, 60; never exceeds 60.
REQ-033 tgt_valid=1 with tgt_pos=0 at counter=99 -> tgt_ready=0, not accepted; held valid, accepted at counter=0; first step appears at the following wrap.
REQ-034 Mid-slew toward 20 at pulse_width=27, accept tgt_pos=40 then tgt_pos=25 in the same frame -> next wrap gives 31 (target 35), then 35, then IDLE.
REQ-035 clr_pwm low for 1 cycle while pulse_width=43 and slewing -> next cycle pulse_width=35, busy=0, counter=0, no pw_update.
